// File: rtl/cache_pkg.sv
// Shared sizes and sequencer state encoding for the cache line transfer path.
package cache_pkg;
    localparam int LINE_W     = 512;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int BEATS      = LINE_W / WORD_W;
    localparam int OFFSET_W   = 6;
    localparam int WORD_IDX_W = 4;
    localparam int WORD_LSB_W = $clog2(WORD_W);

    localparam logic [WORD_IDX_W-1:0] LAST_BEAT = WORD_IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } xfer_state_e;
endpackage

// File: rtl/line_word_mux.sv
// Picks one 32-bit word out of a 512-bit cache line.
module line_word_mux
    import cache_pkg::*;
(
    input  logic [LINE_W-1:0]     line,
    input  logic [WORD_IDX_W-1:0] idx,
    output logic [WORD_W-1:0]     word
);
    assign word = line[{idx, {WORD_LSB_W{1'b0}}} +: WORD_W];
endmodule

// File: rtl/cache_block_xfer_seq.sv
// Sequences a 64-byte write-back and/or refill as 16 single-word bus beats.
// CACHE_XFER_CRITICAL_WORD_FIRST_EN: refill starts at the requested word and pulses early_valid.
module cache_block_xfer_seq
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    output logic [LINE_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] early_word,
    output logic              early_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic [1:0]        state_dbg
);
    xfer_state_e                  state;
    logic [WORD_IDX_W-1:0]        cnt;
    logic [WORD_IDX_W-1:0]        start_q;
    logic [WORD_IDX_W-1:0]        start;
    logic [WORD_IDX_W-1:0]        idx;
    logic [ADDR_W-OFFSET_W-1:0]   fill_line_q;
    logic [ADDR_W-OFFSET_W-1:0]   wb_line_q;
    logic [LINE_W-1:0]            wb_data_q;
    logic                         rd_q;
    logic [WORD_W-1:0]            wb_word;
    logic                         unused_addr_bits;

`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
    assign start = start_q;
`else
    assign start       = '0;
    assign early_valid = 1'b0;
    assign early_word  = '0;
`endif

    assign idx       = start + cnt;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign unused_addr_bits = ^{fill_addr[1:0], wb_addr[OFFSET_W-1:0], start_q};

    line_word_mux u_wb_mux (
        .line (wb_data_q),
        .idx  (cnt),
        .word (wb_word)
    );

    // Beat address/data derive from registers that only move on an ack,
    // so they stay stable across any number of stall cycles.
    always_comb begin
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            WB: begin
                bus_we    = 1'b1;
                bus_addr  = {wb_line_q, cnt, 2'b00};
                bus_wdata = wb_word;
            end
            FILL:    bus_addr = {fill_line_q, idx, 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            cnt         <= '0;
            start_q     <= '0;
            fill_line_q <= '0;
            wb_line_q   <= '0;
            wb_data_q   <= '0;
            rd_q        <= 1'b0;
            fill_data   <= '0;
            done        <= 1'b0;
            bus_req     <= 1'b0;
`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
            early_valid <= 1'b0;
            early_word  <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
            early_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_write || req_read) begin
                        fill_line_q <= fill_addr[ADDR_W-1:OFFSET_W];
                        start_q     <= fill_addr[OFFSET_W-1:2];
                        wb_line_q   <= wb_addr[ADDR_W-1:OFFSET_W];
                        wb_data_q   <= wb_data;
                        rd_q        <= req_read;
                        cnt         <= '0;
                        state       <= req_write ? WB : FILL;
                    end
                end
                WB: begin
                    if (!bus_req) begin
                        bus_req <= 1'b1;
                    end else if (bus_ack) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == LAST_BEAT) begin
                            // bus_req stays up into FILL so the refill follows without a gap
                            if (rd_q) begin
                                state <= FILL;
                            end else begin
                                state   <= DONE;
                                bus_req <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                FILL: begin
                    if (!bus_req) begin
                        bus_req <= 1'b1;
                    end else if (bus_ack) begin
                        fill_data[{idx, {WORD_LSB_W{1'b0}}} +: WORD_W] <= bus_rdata;
                        cnt <= cnt + 4'd1;
`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
                        if (cnt == '0) begin
                            early_valid <= 1'b1;
                            early_word  <= bus_rdata;
                        end
`endif
                        if (cnt == LAST_BEAT) begin
                            state   <= DONE;
                            bus_req <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_block_xfer_seq.sv
// Randomised bench for cache_block_xfer_seq: bus responder, beat-order model and line scoreboard.
module tb_cache_block_xfer_seq;
    logic         clk;
    logic         rst_b;
    logic         req_read;
    logic         req_write;
    logic [31:0]  fill_addr;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;
    logic [511:0] fill_data;
    logic         busy;
    logic         done;
    logic [31:0]  early_word;
    logic         early_valid;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ack;
    logic [1:0]   state_dbg;

`ifdef CACHE_XFER_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int max_stall = 0;
    bit det_data = 1'b1;
    int stall = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_wdata_q[$];
    logic        exp_we_q[$];
    logic [31:0] fill_model [16];

    int          xfer_beats = 0;
    int          done_cnt = 0;
    int          early_cnt = 0;
    logic [31:0] first_addr, last_addr, first_wdata, first_rd_addr;
    bit          first_rd_pending = 1'b0;
    bit          last_beat_pending = 1'b0;
    bit          early_pending = 1'b0;
    logic [31:0] early_exp;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [31:0] mon_ea, mon_ed;
    logic        mon_ew;

    cache_block_xfer_seq dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_read    (req_read),
        .req_write   (req_write),
        .fill_addr   (fill_addr),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .fill_data   (fill_data),
        .busy        (busy),
        .done        (done),
        .early_word  (early_word),
        .early_valid (early_valid),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .state_dbg   (state_dbg)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [511:0] model_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = fill_model[i];
        return l;
    endfunction

    // Expected beat list: 16 write beats in word order, then 16 reads from the start word, wrapping.
    function automatic void push_model(input logic rd, input logic wr, input logic [31:0] fa,
                                       input logic [31:0] wa, input logic [511:0] wd);
        int start;
        int w;
        if (wr) begin
            for (int k = 0; k < 16; k++) begin
                exp_addr_q.push_back((wa & 32'hFFFF_FFC0) + 32'(k * 4));
                exp_we_q.push_back(1'b1);
                exp_wdata_q.push_back(wd[k*32 +: 32]);
            end
        end
        start = CWF ? int'(fa[5:2]) : 0;
        if (rd) begin
            for (int k = 0; k < 16; k++) begin
                w = (start + k) % 16;
                exp_addr_q.push_back((fa & 32'hFFFF_FFC0) + 32'(w * 4));
                exp_we_q.push_back(1'b0);
                exp_wdata_q.push_back(32'h0);
            end
        end
        xfer_beats = 0;
        first_rd_pending = rd;
    endfunction

    // bus responder: random 0..max_stall wait cycles before each ack
    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            if (stall == 0) begin
                bus_ack   = 1'b1;
                bus_rdata = det_data ? (32'hA000_0000 + {28'h0, bus_addr[5:2]}) : $urandom;
                stall     = $urandom_range(max_stall, 0);
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
                stall     = stall - 1;
            end
        end else begin
            bus_ack = 1'b0;
        end
    end

    // compare process, every cycle on the falling edge
    always @(negedge clk) begin
        if (!rst_b) begin
            chk("reset_done", done, 1'b0);
            chk("reset_bus_req", bus_req, 1'b0);
            last_beat_pending = 1'b0;
            early_pending = 1'b0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            chk("done", done, last_beat_pending);
            if (done) done_cnt++;
            if (last_beat_pending) chk("fill_data", fill_data, model_line());
            last_beat_pending = 1'b0;
            chk("early_valid", early_valid, early_pending);
            if (early_valid) early_cnt++;
            if (early_pending) chk("early_word", early_word, early_exp);
            early_pending = 1'b0;
            if (!busy) chk("idle_bus_req", bus_req, 1'b0);
            if (prev_req && !prev_ack && bus_req) begin
                chk("stall_addr", bus_addr, prev_addr);
                chk("stall_wdata", bus_wdata, prev_wdata);
                chk("stall_we", bus_we, prev_we);
            end
            if (bus_req && bus_ack) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got beat at %0h expected none", bus_addr);
                end else begin
                    mon_ea = exp_addr_q.pop_front();
                    mon_ew = exp_we_q.pop_front();
                    mon_ed = exp_wdata_q.pop_front();
                    chk("beat_addr", bus_addr, mon_ea);
                    chk("beat_we", bus_we, mon_ew);
                    if (mon_ew) begin
                        chk("beat_wdata", bus_wdata, mon_ed);
                    end else begin
                        fill_model[mon_ea[5:2]] = bus_rdata;
                        if (first_rd_pending) begin
                            first_rd_pending = 1'b0;
                            first_rd_addr = bus_addr;
                            early_pending = CWF;
                            early_exp = bus_rdata;
                        end
                    end
                    if (xfer_beats == 0) begin
                        first_addr = bus_addr;
                        first_wdata = bus_wdata;
                    end
                    last_addr = bus_addr;
                    xfer_beats++;
                    if (exp_addr_q.size() == 0) last_beat_pending = 1'b1;
                end
            end
            prev_req   = bus_req;
            prev_ack   = bus_ack;
            prev_addr  = bus_addr;
            prev_wdata = bus_wdata;
            prev_we    = bus_we;
        end
    end

    // driver tasks
    task automatic wait_done(input bit pulse_wr, input logic wr);
        int n;
        bit pulsed;
        n = 0;
        pulsed = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (pulse_wr) begin
                if (!pulsed && xfer_beats == 4) begin
                    req_write = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    req_write = wr;
                end
            end
        end while (!done && n < 2000);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] fa, input logic [31:0] wa,
                            input logic [511:0] wd, input bit hold_extra, input bit pulse_wr, output int lat);
        int accept_cyc;
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_read  = rd;
        req_write = wr;
        fill_addr = fa;
        wb_addr   = wa;
        wb_data   = wd;
        push_model(rd, wr, fa, wa, wd);
        @(posedge clk); #1;
        accept_cyc = cyc;
        chk("busy_after_accept", busy, 1'b1);
        wait_done(pulse_wr, wr);
        lat = cyc - accept_cyc + 1;
        if (hold_extra) begin
            @(posedge clk); #1;
            push_model(rd, wr, fa, wa, wd);
            @(posedge clk); #1;
            req_read  = 1'b0;
            req_write = 1'b0;
            chk("busy_restart", busy, 1'b1);
            wait_done(1'b0, 1'b0);
        end
        @(posedge clk); #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        chk("busy_after_done", busy, 1'b0);
        chk("done_count", done_cnt - d0, hold_extra ? 2 : 1);
    endtask

    task automatic reset_mid_fill(input logic [31:0] fa);
        int n;
        int d0;
        d0 = done_cnt;
        @(posedge clk); #1;
        req_read  = 1'b1;
        req_write = 1'b0;
        fill_addr = fa;
        push_model(1'b1, 1'b0, fa, 32'h0, 512'h0);
        n = 0;
        while (xfer_beats < 7 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("beats_before_reset", xfer_beats, 7);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fill_data", fill_data, 512'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        exp_addr_q.delete();
        exp_we_q.delete();
        exp_wdata_q.delete();
        for (int i = 0; i < 16; i++) fill_model[i] = 32'h0;
        first_rd_pending = 1'b0;
        req_read = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_b = 1'b1;
        chk("done_during_reset", done_cnt - d0, 0);
    endtask

    initial begin
        int lat;
        logic [511:0] wd;
        logic rd, wr;
        logic [31:0] fa, wa;

        req_read  = 1'b0;
        req_write = 1'b0;
        fill_addr = '0;
        wb_addr   = '0;
        wb_data   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        rst_b     = 1'b0;
        for (int i = 0; i < 16; i++) fill_model[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_bus_we", bus_we, 1'b0);
        chk("reset_bus_wdata", bus_wdata, 32'h0);
        chk("reset_fill", fill_data, 512'h0);
        chk("reset_early_valid", early_valid, 1'b0);
        chk("reset_early_word", early_word, 32'h0);
        chk("reset_state", state_dbg, 2'd0);
        #1;
        rst_b = 1'b1;

        // read-only, zero-wait
        run_xfer(1'b1, 1'b0, 32'h0000_1040, 32'h0, 512'h0, 1'b0, 1'b0, lat);
        chk("t1_latency", lat, 18);
        chk("t1_first_addr", first_addr, 32'h0000_1040);
        chk("t1_last_addr", last_addr, 32'h0000_107C);
        chk("t1_beats", xfer_beats, 16);
        chk("t1_word5", fill_data[5*32 +: 32], 32'hA000_0005);
        chk("t1_word15", fill_data[15*32 +: 32], 32'hA000_000F);

        // write-back then refill, zero-wait
        for (int k = 0; k < 16; k++) wd[k*32 +: 32] = 32'h5500_0000 + 32'(k);
        run_xfer(1'b1, 1'b1, 32'h0000_3000, 32'h0002_2000, wd, 1'b0, 1'b0, lat);
        chk("t2_latency", lat, 34);
        chk("t2_first_addr", first_addr, 32'h0002_2000);
        chk("t2_first_wdata", first_wdata, 32'h5500_0000);
        chk("t2_last_addr", last_addr, 32'h0000_303C);
        chk("t2_beats", xfer_beats, 32);

        // requested word 13
        begin
            int e0;
            e0 = early_cnt;
            run_xfer(1'b1, 1'b0, 32'h0000_1074, 32'h0, 512'h0, 1'b0, 1'b0, lat);
            chk("t3_first_rd_addr", first_rd_addr, CWF ? 32'h0000_1074 : 32'h0000_1040);
            chk("t3_early_pulses", early_cnt - e0, CWF ? 1 : 0);
            chk("t3_early_word", early_word, CWF ? 32'hA000_000D : 32'h0);
            chk("t3_word13", fill_data[13*32 +: 32], 32'hA000_000D);
            chk("t3_word0", fill_data[0 +: 32], 32'hA000_0000);
        end

        // req_write pulsed mid-refill is ignored
        run_xfer(1'b1, 1'b0, 32'h0000_5100, 32'h0, 512'h0, 1'b0, 1'b1, lat);
        chk("t4_beats", xfer_beats, 16);

        // request held one cycle past done restarts exactly once
        run_xfer(1'b1, 1'b0, 32'h0000_6000, 32'h0, 512'h0, 1'b1, 1'b0, lat);
        chk("t5_beats", xfer_beats, 16);

        // async reset in the middle of a refill, then a clean transfer
        reset_mid_fill(32'h0000_7040);
        run_xfer(1'b1, 1'b0, 32'h0000_7040, 32'h0, 512'h0, 1'b0, 1'b0, lat);
        chk("t6_first_addr", first_addr, 32'h0000_7040);
        chk("t6_beats", xfer_beats, 16);

        // random traffic with 0-3 cycle ack stalls
        max_stall = 3;
        det_data = 1'b0;
        for (int t = 0; t < 12; t++) begin
            rd = 1'($urandom_range(1, 0));
            wr = 1'($urandom_range(1, 0));
            if (!rd && !wr) rd = 1'b1;
            fa = $urandom;
            wa = $urandom;
            for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom;
            run_xfer(rd, wr, fa, wa, wd, 1'b0, 1'b0, lat);
            chk("rand_beats", xfer_beats, (rd ? 16 : 0) + (wr ? 16 : 0));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_block_xfer_seq.md
Name: cache_block_xfer_seq

Overview:
- Sequences 64-byte line transfers between the 4-way cache controller and a 32-bit-wide memory bus.
- Accepts the controller's block-level mem_read / mem_write commands, with a 512-bit victim line and a 32-bit address.
- Runs write-back beats first (if requested), then refill beats, assembling a 512-bit fill line.
- Pulses done when the whole sequence is complete. Sits between the cache controller FSM and the external memory port.

Parameters:
- LINE_W, 512, cache line width in bits.
- WORD_W, 32, memory bus data width in bits.
- ADDR_W, 32, address width.
- BEATS, LINE_W/WORD_W = 16, beats per line (derived; not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- req_read  in  1  refill request (from controller mem_read).
- req_write  in  1  write-back request (from controller mem_write).
- fill_addr  in  ADDR_W  refill address; bits [5:2] give the requested word.
- wb_addr  in  ADDR_W  victim line address; low 6 bits ignored.
- wb_data  in  LINE_W  victim line data; word k is bits [32k+31:32k].
- fill_data  out  LINE_W  assembled refill line; valid while done=1.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle completion pulse.
- early_word  out  WORD_W  first refill word received (feature only).
- early_valid  out  1  one-cycle pulse with early_word (feature only).
- bus_req  out  1  beat request, held until acked.
- bus_we  out  1  1 = write beat, 0 = read beat.
- bus_addr  out  ADDR_W  beat address, word-aligned.
- bus_wdata  out  WORD_W  write beat data.
- bus_rdata  in  WORD_W  read beat data, valid with bus_ack.
- bus_ack  in  1  beat completes on the edge where bus_req and bus_ack are both 1.

Behaviour:
- Reset values: all outputs 0, state IDLE, beat counter 0, latched registers 0. Reset is asynchronous and may be asserted at any time, including mid-burst: the sequencer returns to IDLE immediately, the partial fill is discarded, and done is not asserted.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - Requests are sampled only in IDLE and are ignored in all other states.
  - On entry from IDLE, latch fill_addr, wb_addr, wb_data and req_read.
  - req_write=1 → WB. req_read=1 only → FILL. Neither → stay in IDLE.
- WB:
  - bus_we=1; bus_addr = {wb_addr[31:6], cnt, 2'b00}; bus_wdata = latched word cnt.
  - cnt increments on each acked beat.
  - After beat 15 acks: go to FILL if req_read was latched, else DONE.
- FILL:
  - bus_we=0; bus_addr = {fill_addr[31:6], idx, 2'b00}, where idx = (start + cnt) mod 16 and start = 0 (see Optional Feature).
  - On each ack, write bus_rdata into fill_data word idx.
  - After the 16th ack → DONE.
- DONE: done=1 for exactly one cycle, then IDLE. fill_data holds until the next FILL writes to it.
- Requester rules: hold req_* stable from acceptance until done; drop req_* on the edge after done is seen. A request still high in IDLE restarts a transfer.
- Bus timing:
  - bus_req rises the cycle after state entry and stays high between beats within a phase.
  - One beat per ack; zero-wait acks give back-to-back beats.
  - bus_req=0 in IDLE and DONE.
  - bus_addr and bus_wdata are stable while bus_req=1 and not acked.
- Counter: cnt is 4 bits and wraps 15→0 at each phase change.
- Latency with zero-wait acks: read-only 18 cycles accept→done; write+read 34 cycles.

Optional Feature:
- Macro: CACHE_XFER_CRITICAL_WORD_FIRST_EN.
- Defined:
  - start = fill_addr[5:2]; refill order wraps modulo 16.
  - early_valid pulses on the first FILL ack, with early_word = that beat's data.
- Undefined:
  - start = 0.
  - early_valid and early_word are tied to 0.

Decomposition:
- Shared package cache_pkg: LINE_W, WORD_W, ADDR_W, BEATS, OFFSET_W=6, WORD_IDX_W=4, and the state enum (IDLE/WB/FILL/DONE).
- One natural sub-module, line_word_mux: selects word idx of a 512-bit line. Reused for bus_wdata and the controller's read path.

Test Plan:
- Read-only, zero-wait acks, fill_addr=0x0000_1040:
  - bus_addr runs 0x1040..0x107C in 16 beats.
  - bus_rdata = 0xA000_0000+k; fill_data word k = 0xA000_0000+k.
  - done exactly once, 18 cycles after accept.
- Write+read, wb_addr=0x0002_2000, wb_data word k = 0x5500_0000+k:
  - 16 write beats to 0x22000..0x2203C with matching data, then 16 read beats; done once.
- Random ack stalls of 0-3 cycles: bus_addr and bus_wdata stable while stalled; beat count exactly 16 per phase; fill_data correct.
- Reset at beat 7 of FILL:
  - bus_req=0, busy=0, done never pulses.
  - A new request after reset completes normally from beat 0.
- With CACHE_XFER_CRITICAL_WORD_FIRST_EN, fill_addr=0x1074:
  - Read order is words 13,14,15,0..12.
  - early_valid on the first ack, early_word = word 13.
  - Without the macro, order is 0..15 and early_valid stays 0.
- Request pulse while busy (req_write during FILL): ignored, no extra beats. Request held one cycle past done: exactly one restart.
